// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit path.
package UartStruct;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_serializer_byte_fifo.sv
// Synchronous byte FIFO with a registered head-of-queue output, so rd_data
// already holds the oldest entry in the first cycle that empty is low.
module uart_byte_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  wr_data,
    output logic [7:0]                  rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          push_ok_s, pop_ok_s;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == CW'(0));
    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer, occupancy and head-register next state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The slot being written becomes the head when it is the only entry left.
        if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop bit FSM.
// All outputs are registered from the FSM's next state so they line up with it.
module uart_tx_serializer
    import UartStruct::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]    BIDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           txd_q, txd_d;
    logic           tx_done_q, tx_done_d;
    logic           tx_busy_q, tx_busy_d;

    logic           push_s, pop_s;
    logic           fifo_full_s, fifo_empty_s;
    logic [7:0]     fifo_rd_data_s;
    logic [CW-1:0]  count_nxt_s;

    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;
    assign txd      = txd_q;
    assign tx_done  = tx_done_q;
    assign tx_busy  = tx_busy_q;

    uart_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (in_data),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    // Bit-timing FSM plus next-cycle values of the registered outputs.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shreg_d = fifo_rd_data_s;
                    bcnt_d  = '0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d  = '0;
                    bidx_d  = 3'd0;
                    state_d = DATA;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            DATA: begin
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bidx_q == BIDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            STOP: begin
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d = '0;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shreg_d = fifo_rd_data_s;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
                bidx_d  = 3'd0;
            end
        endcase

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = fifo_count + CW'(1);
            2'b01:   count_nxt_s = fifo_count - CW'(1);
            default: count_nxt_s = fifo_count;
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
        tx_done_d = (state_d == STOP) && (bcnt_d == BCNT_LAST);
        tx_busy_d = (state_d != IDLE) || (count_nxt_s != CW'(0));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            bidx_q    <= 3'd0;
            shreg_q   <= 8'h00;
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
            tx_busy_q <= tx_busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and randomized bench for uart_tx_serializer; a line decoder turns
// txd back into bytes and frame timestamps for comparison.
module tb_uart_tx_serializer;
    import UartStruct::*;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME      = UART_FRAME_BITS * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, txd, tx_busy, tx_done;
    logic [CW-1:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    uart_tx_serializer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Line decoder: frames start on a low txd, every bit must hold for CLK_DIV cycles.
    int         m_ncyc = 0;
    int         m_pos = 0;
    int         frame_err = 0;
    int         done_err = 0;
    logic       m_act = 1'b0;
    logic       m_bitv = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         done_q[$];

    always @(negedge clk) begin
        m_ncyc <= m_ncyc + 1;
        if (tx_done === 1'b1) begin
            done_q.push_back(m_ncyc);
            if (!(m_act && m_pos == FRAME - 1)) done_err <= done_err + 1;
        end
        if (rst) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (txd === 1'b0) begin
                m_act  <= 1'b1;
                m_pos  <= 1;
                m_bitv <= 1'b0;
                start_q.push_back(m_ncyc);
            end
        end else begin
            if ((m_pos % CLK_DIV) == 0) begin
                m_bitv <= txd;
                if ((m_pos / CLK_DIV) == UART_FRAME_BITS - 1 && txd !== 1'b1)
                    frame_err <= frame_err + 1;
            end else if (txd !== m_bitv) begin
                frame_err <= frame_err + 1;
            end
            if ((m_pos % CLK_DIV) == CLK_DIV / 2 && (m_pos / CLK_DIV) >= 1 &&
                (m_pos / CLK_DIV) <= UART_DATA_BITS)
                m_byte <= {txd, m_byte[7:1]};
            if (m_pos == FRAME - 1) begin
                rx_q.push_back(m_byte);
                m_act <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level i cycles into a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CLK_DIV;
        if (k == 0) return 1'b0;
        else if (k <= UART_DATA_BITS) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a byte on the input until a handshake edge; waits = cycles stalled.
    task automatic offer(input logic [7:0] b, output int waits, output bit ok);
        logic r;
        in_valid = 1'b1;
        in_data  = b;
        waits    = 0;
        ok       = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
            else waits++;
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (rx_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    initial begin
        int         base, sbase, dbase, e0, w, gap, nrand;
        bit         ok;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        // Reset values
        rst = 1'b1;
        wait_edges(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);

        // Single byte 0xA5 pushed at edge 10
        while (ecnt < 9) begin
            @(posedge clk);
            #1;
        end
        base     = rx_q.size();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_count", fifo_count, 1);
        chk("t1_busy", tx_busy, 1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("t1_txd", txd, frame_bit(8'hA5, i));
            chk("t1_done", tx_done, (i == FRAME - 1));
        end
        @(negedge clk);
        chk("t1_busy_fall", tx_busy, 0);
        wait_rx(base + 1, 10, "t1_rx");
        if (rx_q.size() > base) chk("t1_byte", rx_q[base], 8'hA5);

        // Back-to-back frames
        wait_edges(5);
        base  = rx_q.size();
        sbase = start_q.size();
        dbase = done_q.size();
        offer(8'h00, w, ok);
        offer(8'hFF, w, ok);
        in_valid = 1'b0;
        wait_rx(base + 2, 3 * FRAME, "t2_rx");
        if (rx_q.size() >= base + 2) begin
            chk("t2_byte0", rx_q[base], 8'h00);
            chk("t2_byte1", rx_q[base+1], 8'hFF);
        end
        chk("t2_starts", start_q.size(), sbase + 2);
        chk("t2_dones", done_q.size(), dbase + 2);
        if (start_q.size() >= sbase + 2)
            chk("t2_start_gap", start_q[sbase+1] - start_q[sbase], FRAME);
        if (done_q.size() >= dbase + 2)
            chk("t2_done_gap", done_q[dbase+1] - done_q[dbase], FRAME);

        // Full FIFO: 1 popped at once, 4 queued, then one slot per frame
        wait_edges(5);
        base = rx_q.size();
        for (int v = 1; v <= 8; v++) begin
            offer(8'(v), w, ok);
            chk("t3_accept", ok, 1);
            chk("t3_stall", w, (v <= 5) ? 0 : ((v == 6) ? 37 : 39));
            if (v == 5) begin
                chk("t3_full_count", fifo_count, 4);
                chk("t3_full_ready", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        wait_rx(base + 8, 10 * FRAME, "t3_rx");
        for (int v = 0; v < 8; v++)
            if (rx_q.size() > base + v) chk("t3_order", rx_q[base+v], v + 1);

        // Push on the stop-end edge while two bytes are queued
        wait_edges(5);
        base = rx_q.size();
        offer(8'h11, w, ok);
        e0 = ecnt;
        offer(8'h22, w, ok);
        offer(8'h33, w, ok);
        in_valid = 1'b0;
        while (ecnt < e0 + 40) begin
            @(posedge clk);
            #1;
        end
        chk("t4_count_pre", fifo_count, 2);
        chk("t4_done", tx_done, 1);
        in_valid = 1'b1;
        in_data  = 8'h44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_count_post", fifo_count, 2);
        wait_rx(base + 4, 5 * FRAME, "t4_rx");
        for (int i = 0; i < 4; i++)
            if (rx_q.size() > base + i) chk("t4_order", rx_q[base+i], 8'h11 * (i + 1));

        // Reset during data bit 3 with two bytes queued
        wait_edges(5);
        offer(8'h5A, w, ok);
        e0 = ecnt;
        offer(8'h3C, w, ok);
        offer(8'hC3, w, ok);
        in_valid = 1'b0;
        while (ecnt < e0 + 18) begin
            @(posedge clk);
            #1;
        end
        chk("t5_queued", fifo_count, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_txd", txd, 1);
        chk("t5_count", fifo_count, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_busy", tx_busy, 0);
        base  = rx_q.size();
        sbase = start_q.size();
        wait_edges(3 * FRAME);
        chk("t5_no_rx", rx_q.size(), base);
        chk("t5_no_start", start_q.size(), sbase);

        // Pointer wrap-around with a continuously non-empty FIFO
        base  = rx_q.size();
        sbase = start_q.size();
        for (int i = 0; i < 20; i++) begin
            offer(8'h30 + 8'(i), w, ok);
            chk("t6_accept", ok, 1);
        end
        in_valid = 1'b0;
        wait_rx(base + 20, 25 * FRAME, "t6_rx");
        for (int i = 0; i < 20; i++)
            if (rx_q.size() > base + i) chk("t6_order", rx_q[base+i], 8'h30 + i);
        for (int i = 1; i < 20; i++)
            if (start_q.size() > sbase + i)
                chk("t6_gap", start_q[sbase+i] - start_q[sbase+i-1], FRAME);

        // Random bytes with random idle gaps
        base  = rx_q.size();
        nrand = 12;
        for (int i = 0; i < nrand; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 2 * FRAME);
            wait_edges(gap);
            offer(b, w, ok);
            if (ok) exp_q.push_back(b);
            chk("t7_accept", ok, 1);
            in_valid = 1'b0;
        end
        wait_rx(base + exp_q.size(), (nrand + 2) * FRAME, "t7_rx");
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_q.size() > base + i) chk("t7_data", rx_q[base+i], exp_q[i]);

        wait_edges(5);
        chk("frame_errors", frame_err, 0);
        chk("done_errors", done_err, 0);
        chk("done_vs_frames", done_q.size(), rx_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit side of the UART path, downstream of the CPU top's `uart_ift` master port. Accepts bytes from the MMIO UART slave over a valid/ready handshake, buffers them in a small byte FIFO, and serialises each one onto the `txd` pin as an 8N1 frame timed by a programmable baud divider. One clock domain; no receive path.

## Interface
- `CLK_DIV`, 868: clock cycles per bit (100 MHz / 115200). Legal range ≥2.
- `FIFO_DEPTH`, 16: byte FIFO entries. Must be a power of 2, ≥2.

- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `in_valid` in 1: a byte is offered on `in_data`.
- `in_data` in 8: the byte to transmit.
- `in_ready` out 1: FIFO can accept. Equal to `fifo_count < FIFO_DEPTH`.
- `txd` out 1: serial line. Idle high. Driven from a register.
- `tx_busy` out 1: high while the FSM is not IDLE or the FIFO is not empty.
- `tx_done` out 1: one-cycle pulse on the last cycle of each stop bit.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: on an edge where `in_valid && in_ready`, write `in_data` to the tail. When full, `in_ready`=0 and the byte is not accepted. There is no bypass and no same-cycle push-when-full, even if a pop occurs.
- Pop: done only by the FSM. Push and pop may occur on the same edge when not full, and `fifo_count` is then unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP. There is a baud counter `bcnt` (0..CLK_DIV-1) and a bit index `bidx` (0..7).
  - IDLE: `txd`=1. If FIFO is non-empty, pop into `shreg`, clear `bcnt`, and go to START.
  - START: `txd`=0. When `bcnt`==CLK_DIV-1, clear `bcnt` and `bidx`, and go to DATA. Otherwise increment `bcnt`.
  - DATA: `txd`=`shreg[0]` (LSB first). At `bcnt`==CLK_DIV-1, shift `shreg` right. If `bidx`==7, go to STOP; otherwise increment `bidx`.
  - STOP: `txd`=1. At `bcnt`==CLK_DIV-1, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START (back-to-back, no idle bit). Otherwise go to IDLE.
- Reset values: FSM=IDLE, `txd`=1, `tx_done`=0, `tx_busy`=0, `fifo_count`=0, `in_ready`=1, pointers=0, `bcnt`=0, `bidx`=0.
- Reset mid-frame: on the next edge, `txd`=1 and the FIFO is emptied. Any partial frame and all queued bytes are discarded.

## Timing
- Byte accepted at edge t into an empty FIFO with the FSM in IDLE:
  - `fifo_count`=1 during cycle t+1.
  - Pop at edge t+1.
  - `txd`=0 from t+2 for CLK_DIV cycles.
- Frame length is exactly 10·CLK_DIV cycles, from the first start-bit cycle to the last stop-bit cycle.
- `tx_done` is asserted in the final stop-bit cycle.
- With a non-empty FIFO, the next start bit begins on the cycle immediately after the stop bit ends, giving back-to-back frames with period 10·CLK_DIV.
- `in_ready` and `fifo_count` reflect registered state only. There is no combinational path from `in_valid` to `in_ready`.
- `txd` is glitch-free because it comes straight from a flop.

## Structure
- Package `UartStruct` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - `UART_FRAME_BITS`=10.
- Sub-module `uart_byte_fifo` is parameterised by `FIFO_DEPTH`. It is a synchronous FIFO with `push`/`pop`/`full`/`empty`/`count` and registered read data valid in the cycle after `!empty`. The serializer top holds only the FSM, the counters and `shreg`.
- Expected size: ~200 lines of RTL in total.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Single byte: push 0xA5 at edge 10.
  - `txd` low during cycles 12–15.
  - Then the bits 1,0,1,0,0,1,0,1 follow, 4 cycles each.
  - Stop bit high during cycles 48–51, with `tx_done` pulsed at cycle 51.
  - `tx_busy` falls at cycle 52.
- Back-to-back: push 0x00 then 0xFF on consecutive edges.
  - The second start bit begins exactly 40 cycles after the first.
  - `txd` has no idle cycle between the frames.
  - `tx_done` pulses twice, 40 cycles apart.
- Full FIFO: hold `in_valid`=1 with bytes 0x01..0x08.
  - 5 bytes are accepted: 1 popped immediately, 4 queued.
  - `in_ready`=0 until the first pop from the FIFO.
  - The bytes on the line are in exactly the accepted order, with none lost or duplicated.
- Simultaneous push/pop: with `fifo_count`=2, push on the stop-end edge. `fifo_count` stays 2.
- Reset mid-frame: assert `rst` in DATA bit 3 with 2 bytes queued.
  - The next cycle shows `txd`=1, `fifo_count`=0, `in_ready`=1, `tx_busy`=0.
  - No further frames appear.
- Wrap-around: stream 20 bytes 0x30..0x43 while keeping the FIFO non-empty. The decoded output matches the input exactly.
